// File: rtl/pic_isr_control.sv
// 8259 PIC in-service control: fixed-priority resolution, two-pulse INTA handshake, vector drive and EOI.
// Optional: define PIC_AUTO_EOI_EN to clear the acknowledged ISR bit automatically at the end of the second INTA.
module pic_isr_control #(
    parameter int SPURIOUS_LEVEL = 7,
    parameter int NUM_IRQ        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       inta,
    input  logic [4:0] vector_base,
    input  logic       eoi_ns,
    input  logic       eoi_sp,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] ack_level,
    output logic [7:0] data_out,
    output logic       data_en
);

    localparam logic [3:0] NO_LEVEL = 4'(NUM_IRQ);
    localparam logic [2:0] SPUR_LVL = 3'(SPURIOUS_LEVEL);

    typedef enum logic [1:0] {IDLE, WAIT1, ACK1, ACK2} state_t;

    state_t     state, next_state;
    logic       inta_q;
    logic       rise_seen;
    logic [2:0] lvl;
    logic       fall, rise;
    logic [7:0] cand;
    logic [3:0] sel, top;
    logic       qualify;
    logic       int_set, take_ack, drive, release_bus;
    logic [7:0] set_vec, clr_vec, auto_clr;

    // Returns NO_LEVEL when no bit is set, so an empty ISR never blocks a request.
    function automatic logic [3:0] lowest_idx(input logic [7:0] v);
        lowest_idx = NO_LEVEL;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i);
        end
    endfunction

    assign fall    = inta_q & ~inta;
    assign rise    = ~inta_q & inta;
    assign cand    = irr & ~imr;
    assign sel     = lowest_idx(cand);
    assign top     = lowest_idx(isr);
    assign qualify = (cand != 8'h00) && (sel < top);

    always_comb begin
        next_state  = state;
        int_set     = 1'b0;
        take_ack    = 1'b0;
        drive       = 1'b0;
        release_bus = 1'b0;
        case (state)
            IDLE: begin
                if (qualify) begin
                    int_set    = 1'b1;
                    next_state = WAIT1;
                end
            end
            WAIT1: begin
                if (fall) begin
                    take_ack   = 1'b1;
                    next_state = ACK1;
                end
            end
            ACK1: begin
                if (rise_seen && fall) begin
                    drive      = 1'b1;
                    next_state = ACK2;
                end
            end
            ACK2: begin
                if (rise) begin
                    release_bus = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign set_vec = (take_ack && qualify) ? (8'b1 << sel[2:0]) : 8'h00;

`ifdef PIC_AUTO_EOI_EN
    logic spurious;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           spurious <= 1'b0;
        else if (take_ack) spurious <= ~qualify;
    end

    assign auto_clr = (release_bus && !spurious) ? (8'b1 << lvl) : 8'h00;
`else
    assign auto_clr = 8'h00;
`endif

    // Clears come from the pre-edge ISR, so an EOI and a first-INTA set in one cycle both land.
    assign clr_vec = (eoi_ns ? (isr & (~isr + 8'd1)) : 8'h00)
                   | (eoi_sp ? (8'b1 << eoi_level) : 8'h00)
                   | auto_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inta_q    <= 1'b1;
            rise_seen <= 1'b0;
            lvl       <= 3'd0;
            isr       <= 8'h00;
            int_out   <= 1'b0;
            ack_level <= 8'h00;
            data_out  <= 8'h00;
            data_en   <= 1'b0;
        end else begin
            inta_q    <= inta;
            isr       <= (isr & ~clr_vec) | set_vec;
            ack_level <= set_vec;
            if (int_set)       int_out <= 1'b1;
            else if (take_ack) int_out <= 1'b0;
            if (take_ack) lvl <= qualify ? sel[2:0] : SPUR_LVL;
            if (take_ack)                     rise_seen <= 1'b0;
            else if (state == ACK1 && rise)   rise_seen <= 1'b1;
            if (drive) begin
                data_out <= {vector_base, lvl};
                data_en  <= 1'b1;
            end else if (release_bus) begin
                data_en  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pic_isr_control.sv
// Directed self-checking bench for pic_isr_control; follows PIC_AUTO_EOI_EN when it is defined.
module tb_pic_isr_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irr = 8'h00;
    logic [7:0] imr = 8'h00;
    logic       inta = 1'b1;
    logic [4:0] vector_base = 5'b01000;
    logic       eoi_ns = 1'b0;
    logic       eoi_sp = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] ack_level;
    logic [7:0] data_out;
    logic       data_en;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef PIC_AUTO_EOI_EN
    localparam logic [7:0] ISR_AFTER_L3 = 8'h00;
`else
    localparam logic [7:0] ISR_AFTER_L3 = 8'h08;
`endif

    pic_isr_control dut (
        .clk(clk), .rst(rst), .irr(irr), .imr(imr), .inta(inta),
        .vector_base(vector_base), .eoi_ns(eoi_ns), .eoi_sp(eoi_sp),
        .eoi_level(eoi_level), .int_out(int_out), .isr(isr),
        .ack_level(ack_level), .data_out(data_out), .data_en(data_en)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Two complete INTA pulses starting from WAIT1.
    task automatic do_full_ack;
        inta = 1'b0; cyc(1);
        inta = 1'b1; cyc(1);
        inta = 1'b0; cyc(1);
        inta = 1'b1; cyc(1);
    endtask

    task automatic pulse_eoi_ns;
        eoi_ns = 1'b1; cyc(1); eoi_ns = 1'b0;
    endtask

    task automatic pulse_eoi_sp(input logic [2:0] l);
        eoi_sp = 1'b1; eoi_level = l; cyc(1); eoi_sp = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cyc(2);
        total_cnt++; if (isr !== 8'h00) $display("[TB] FAIL reset_isr: got %h expected 00", isr); else pass_cnt++;
        total_cnt++; if (int_out !== 1'b0) $display("[TB] FAIL reset_int: got %b expected 0", int_out); else pass_cnt++;
        total_cnt++; if (ack_level !== 8'h00) $display("[TB] FAIL reset_ack: got %h expected 00", ack_level); else pass_cnt++;
        total_cnt++; if (data_en !== 1'b0 || data_out !== 8'h00) $display("[TB] FAIL reset_data: got en=%b out=%h expected en=0 out=00", data_en, data_out); else pass_cnt++;
        rst = 1'b0; cyc(1);
    endtask

    task automatic test_basic_ack;
        irr = 8'h01; imr = 8'h00; vector_base = 5'b01000; cyc(1);
        total_cnt++; if (int_out !== 1'b1) $display("[TB] FAIL basic_int: got %b expected 1", int_out); else pass_cnt++;
        inta = 1'b0; cyc(1);
        total_cnt++; if (isr !== 8'h01) $display("[TB] FAIL basic_isr: got %h expected 01", isr); else pass_cnt++;
        total_cnt++; if (ack_level !== 8'h01) $display("[TB] FAIL basic_ack: got %h expected 01", ack_level); else pass_cnt++;
        total_cnt++; if (int_out !== 1'b0) $display("[TB] FAIL basic_int_drop: got %b expected 0", int_out); else pass_cnt++;
        irr = 8'h00; cyc(1);
        total_cnt++; if (ack_level !== 8'h00) $display("[TB] FAIL basic_ack_pulse: got %h expected 00", ack_level); else pass_cnt++;
        inta = 1'b1; cyc(1);
        inta = 1'b0; cyc(1);
        total_cnt++; if (data_en !== 1'b1 || data_out !== 8'h40) $display("[TB] FAIL basic_vector: got en=%b out=%h expected en=1 out=40", data_en, data_out); else pass_cnt++;
        cyc(1);
        total_cnt++; if (data_en !== 1'b1) $display("[TB] FAIL basic_hold: got %b expected 1", data_en); else pass_cnt++;
        inta = 1'b1; cyc(1);
        total_cnt++; if (data_en !== 1'b0 || data_out !== 8'h40) $display("[TB] FAIL basic_release: got en=%b out=%h expected en=0 out=40", data_en, data_out); else pass_cnt++;
        pulse_eoi_ns();
    endtask

    task automatic test_priority_mask;
        irr = 8'h55; imr = 8'h01; cyc(1);
        total_cnt++; if (int_out !== 1'b1) $display("[TB] FAIL prio_int: got %b expected 1", int_out); else pass_cnt++;
        inta = 1'b0; cyc(1);
        total_cnt++; if (isr !== 8'h04 || ack_level !== 8'h04) $display("[TB] FAIL prio_isr: got isr=%h ack=%h expected isr=04 ack=04", isr, ack_level); else pass_cnt++;
        irr = 8'h51; cyc(1);
        inta = 1'b1; cyc(1);
        inta = 1'b0; cyc(1);
        total_cnt++; if (data_out !== 8'h42) $display("[TB] FAIL prio_vector: got %h expected 42", data_out); else pass_cnt++;
        inta = 1'b1; cyc(1);
        irr = 8'h00; imr = 8'h00;
        pulse_eoi_ns();
        total_cnt++; if (isr !== 8'h00) $display("[TB] FAIL prio_eoi: got %h expected 00", isr); else pass_cnt++;
    endtask

    task automatic test_nesting;
        irr = 8'h04; cyc(1);
        do_full_ack();
        irr = 8'h08; cyc(2);
        total_cnt++; if (int_out !== 1'b0) $display("[TB] FAIL nest_blocked: got %b expected 0", int_out); else pass_cnt++;
        irr = 8'h02; cyc(1);
        total_cnt++; if (int_out !== 1'b1) $display("[TB] FAIL nest_int: got %b expected 1", int_out); else pass_cnt++;
        do_full_ack();
        total_cnt++; if (isr !== 8'h06) $display("[TB] FAIL nest_isr: got %h expected 06", isr); else pass_cnt++;
        irr = 8'h00;
        pulse_eoi_ns();
        total_cnt++; if (isr !== 8'h04) $display("[TB] FAIL nest_eoi_ns: got %h expected 04", isr); else pass_cnt++;
        pulse_eoi_sp(3'd2);
        total_cnt++; if (isr !== 8'h00) $display("[TB] FAIL nest_eoi_sp: got %h expected 00", isr); else pass_cnt++;
    endtask

    task automatic test_eoi_same_cycle;
        irr = 8'h04; cyc(1);
        do_full_ack();
        irr = 8'h02; cyc(1);
        inta = 1'b0; eoi_sp = 1'b1; eoi_level = 3'd2; cyc(1);
        eoi_sp = 1'b0;
        total_cnt++; if (isr !== 8'h02 || ack_level !== 8'h02) $display("[TB] FAIL same_cycle_isr: got isr=%h ack=%h expected isr=02 ack=02", isr, ack_level); else pass_cnt++;
        irr = 8'h00;
        inta = 1'b1; cyc(1);
        inta = 1'b0; cyc(1);
        total_cnt++; if (data_out !== 8'h41) $display("[TB] FAIL same_cycle_vector: got %h expected 41", data_out); else pass_cnt++;
        inta = 1'b1; cyc(1);
        pulse_eoi_ns();
    endtask

    task automatic test_spurious;
        vector_base = 5'b10101;
        irr = 8'h10; cyc(1);
        irr = 8'h00; cyc(1);
        total_cnt++; if (int_out !== 1'b1) $display("[TB] FAIL spur_int_held: got %b expected 1", int_out); else pass_cnt++;
        inta = 1'b0; cyc(1);
        total_cnt++; if (isr !== 8'h00 || ack_level !== 8'h00) $display("[TB] FAIL spur_isr: got isr=%h ack=%h expected isr=00 ack=00", isr, ack_level); else pass_cnt++;
        inta = 1'b1; cyc(1);
        inta = 1'b0; cyc(1);
        total_cnt++; if (data_en !== 1'b1 || data_out !== 8'hAF) $display("[TB] FAIL spur_vector: got en=%b out=%h expected en=1 out=af", data_en, data_out); else pass_cnt++;
        inta = 1'b1; cyc(1);
        vector_base = 5'b01000;
    endtask

    task automatic test_reset_mid;
        irr = 8'h08; cyc(1);
        inta = 1'b0; cyc(1);
        inta = 1'b1; irr = 8'h00; cyc(1);
        rst = 1'b1; #1;
        total_cnt++; if (isr !== 8'h00 || int_out !== 1'b0) $display("[TB] FAIL mid_reset_isr: got isr=%h int=%b expected isr=00 int=0", isr, int_out); else pass_cnt++;
        total_cnt++; if (data_out !== 8'h00 || data_en !== 1'b0 || ack_level !== 8'h00) $display("[TB] FAIL mid_reset_data: got out=%h en=%b ack=%h expected 00/0/00", data_out, data_en, ack_level); else pass_cnt++;
        cyc(1);
        rst = 1'b0; cyc(1);
        inta = 1'b0; cyc(2);
        total_cnt++; if (data_en !== 1'b0 || int_out !== 1'b0) $display("[TB] FAIL mid_reset_inta: got en=%b int=%b expected en=0 int=0", data_en, int_out); else pass_cnt++;
        inta = 1'b1; cyc(1);
    endtask

    task automatic test_auto_eoi;
        irr = 8'h08; cyc(1);
        inta = 1'b0; cyc(1);
        total_cnt++; if (isr !== 8'h08) $display("[TB] FAIL auto_isr_set: got %h expected 08", isr); else pass_cnt++;
        irr = 8'h00;
        inta = 1'b1; cyc(1);
        inta = 1'b0; cyc(1);
        total_cnt++; if (isr !== 8'h08 || data_out !== 8'h43) $display("[TB] FAIL auto_data: got isr=%h out=%h expected isr=08 out=43", isr, data_out); else pass_cnt++;
        inta = 1'b1; cyc(1);
        total_cnt++; if (isr !== ISR_AFTER_L3) $display("[TB] FAIL auto_isr_end: got %h expected %h", isr, ISR_AFTER_L3); else pass_cnt++;
        pulse_eoi_sp(3'd3);
        total_cnt++; if (isr !== 8'h00) $display("[TB] FAIL auto_cleanup: got %h expected 00", isr); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_priority_mask();
`ifndef PIC_AUTO_EOI_EN
        test_nesting();
        test_eoi_same_cycle();
`endif
        test_spurious();
        test_reset_mid();
        test_auto_eoi();
        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pic_isr_control.md
Name: pic_isr_control

Overview:
- Stage directly downstream of the IRQs request register in the 8259 PIC.
- Takes the latched request vector `irr` and the interrupt mask, resolves fixed priority (IR0 highest) against the in-service register (ISR), and raises `int_out`.
- Runs the two-pulse INTA handshake, returns the one-hot acknowledged level to IRQs (its `priority` input), and drives the interrupt vector.
- Handles non-specific and specific EOI.

Parameters:
- SPURIOUS_LEVEL, 7: level reported when the request vanishes before the first INTA.
- NUM_IRQ, 8: number of request lines. Fixed at 8; other values unsupported.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- irr  input  8  pending requests from IRQs (`irq_status`)
- imr  input  8  mask; 1 = level masked
- inta  input  1  interrupt acknowledge, active-low, synchronous to clk
- vector_base  input  5  ICW2 bits [7:3]
- eoi_ns  input  1  one-cycle pulse: non-specific EOI
- eoi_sp  input  1  one-cycle pulse: specific EOI
- eoi_level  input  3  level cleared by eoi_sp
- int_out  output  1  interrupt request to CPU, active-high
- isr  output  8  in-service register
- ack_level  output  8  one-hot, one-cycle pulse to IRQs `priority`, clearing the acknowledged request
- data_out  output  8  interrupt vector
- data_en  output  1  data_out valid / bus drive enable

Behaviour:
- Reset (async, rst=1): isr=0, int_out=0, ack_level=0, data_out=0, data_en=0, state=IDLE, inta_q=1. Reset mid-handshake aborts to IDLE; no partial ISR bit is retained.
- Edge detect: inta_q registers inta. fall = inta_q & ~inta; rise = ~inta_q & inta.
- Request selection:
  - cand = irr & ~imr; sel = lowest set index of cand.
  - top = lowest set index of isr, or 8 if isr=0.
  - Request qualifies when cand≠0 and sel < top (higher-priority nesting only).
- States:
  - IDLE: qualifying request → int_out=1 next cycle (1-cycle latency), go to WAIT1. A fall in IDLE is ignored.
  - WAIT1: int_out held.
    - If the request disqualifies before the INTA fall, int_out still stays high; the response becomes spurious.
    - On fall: lvl = sel if still qualifying, else SPURIOUS_LEVEL with spurious=1.
    - Non-spurious: set isr[lvl]; ack_level = 1<<lvl for exactly one cycle.
    - int_out=0. Go to ACK1.
  - ACK1: wait for rise then the next fall.
    - On the second fall: data_out = {vector_base, lvl}, data_en=1. Go to ACK2.
  - ACK2: data_en held while inta=0. On rise: data_en=0, data_out holds its value, go to IDLE.
- EOI:
  - eoi_ns clears the lowest-index set isr bit; no-op if isr=0.
  - eoi_sp clears isr[eoi_level].
  - Both asserted together: the two clears are OR-ed.
- ISR update ordering: new_isr = (isr & ~clr) | set. clr is computed from pre-edge isr, so EOI and a first-INTA set in the same cycle both take effect.
- Spurious acknowledge: isr and ack_level are untouched; the vector still carries SPURIOUS_LEVEL.
- Changes to irr/imr after the first fall do not alter lvl.

Optional Feature:
- Macro: PIC_AUTO_EOI_EN.
- Defined: on the ACK2 rise, isr[lvl] is cleared automatically (no-op if spurious); eoi_ns/eoi_sp still function.
- Undefined: isr bits are cleared only by EOI pulses.

Test Plan:
- irr=0x01, imr=0, vector_base=5'b01000 → int_out=1 one cycle later. After two INTA pulses: isr=0x01, ack_level=0x01 pulse on the first fall, data_out=0x40 with data_en=1 during the second pulse.
- irr=0x55, imr=0x01 → first ack selects level 2: isr=0x04, data_out=0x42. A following eoi_ns → isr=0x00.
- isr=0x04 in service, irr=0x08 → int_out stays 0. Then irr=0x02 → int_out=1, acknowledge sets isr=0x06. eoi_ns → isr=0x04.
- int_out=1 from irr=0x10, irr drops to 0 before the first fall → isr unchanged, no ack_level pulse, data_out={vector_base,3'd7}.
- eoi_sp with eoi_level=2 on the same cycle as a first-INTA fall for level 1, with isr=0x04 → isr=0x02.
- rst=1 while in ACK1 → all outputs 0 immediately, and the second INTA pulse produces no data_en.
- With PIC_AUTO_EOI_EN defined: a full ack of level 3 leaves isr=0x00 after the second INTA rises.
